// File: rtl/serpent_key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serpent_key_pkg
// Description : Shared constants and FSM state type for the Serpent round-key
//               store.
// Revision    : 1.0 - initial release
// ============================================================================
package serpent_key_pkg;

    localparam int SERPENT_NUM_SUBKEYS = 33;
    localparam int SERPENT_KEY_W       = 128;

    localparam int BANK_DATA  = 0;
    localparam int BANK_TWEAK = 1;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CLEAR = 2'd2
    } bank_state_t;

endpackage
`default_nettype wire

// File: rtl/key_ram_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : key_ram_2r1w
// Description : Plain storage array, one write port and two registered
//               read-first read ports. No reset on contents or read data.
// Revision    : 1.0 - initial release
// ============================================================================
module key_ram_2r1w #(
    parameter int WIDTH   = 128,
    parameter int ENTRIES = 66,
    parameter int AW      = 7
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rea,
    input  logic [AW-1:0]    i_raddra,
    output logic [WIDTH-1:0] o_qa,
    input  logic             i_reb,
    input  logic [AW-1:0]    i_raddrb,
    output logic [WIDTH-1:0] o_qb
);

    logic [WIDTH-1:0] r_mem [ENTRIES];
    logic [WIDTH-1:0] r_qa;
    logic [WIDTH-1:0] r_qb;

    // Non-blocking update makes a same-cycle read return the old word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_rea) begin
            r_qa <= r_mem[i_raddra];
        end
        if (i_reb) begin
            r_qb <= r_mem[i_raddrb];
        end
    end

    assign o_qa = r_qa;
    assign o_qb = r_qb;

endmodule
`default_nettype wire

// File: rtl/round_key_bank.sv
`default_nettype none
// ============================================================================
// Module      : round_key_bank
// Description : Multi-bank Serpent round-key store with fill tracking, two
//               read ports and an init/zeroize sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module round_key_bank
    import serpent_key_pkg::*;
#(
    parameter int  KEY_W     = SERPENT_KEY_W,
    parameter int  DEPTH     = SERPENT_NUM_SUBKEYS,
    parameter int  NUM_BANKS = 2,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [BANK_W-1:0]    i_wr_bank,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic [KEY_W-1:0]     i_wr_key,
    output logic                 o_wr_err,
    input  logic                 i_rda_en,
    input  logic [BANK_W-1:0]    i_rda_bank,
    input  logic [ADDR_W-1:0]    i_rda_addr,
    output logic [KEY_W-1:0]     o_rda_key,
    output logic                 o_rda_valid,
    output logic                 o_rda_err,
    input  logic                 i_rdb_en,
    input  logic [BANK_W-1:0]    i_rdb_bank,
    input  logic [ADDR_W-1:0]    i_rdb_addr,
    output logic [KEY_W-1:0]     o_rdb_key,
    output logic                 o_rdb_valid,
    output logic                 o_rdb_err,
    input  logic                 i_zero_req,
    input  logic [BANK_W-1:0]    i_zero_bank,
    output logic                 o_busy,
    output logic [NUM_BANKS-1:0] o_bank_loaded
);

    localparam int                 c_ENTRIES    = NUM_BANKS * DEPTH;
    localparam int                 c_IDX_W      = $clog2(c_ENTRIES);
    localparam logic [c_IDX_W-1:0] c_LAST_ENTRY = c_IDX_W'(c_ENTRIES - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_ADDR  = c_IDX_W'(DEPTH - 1);
    localparam logic [c_IDX_W-1:0] c_DEPTH_IDX  = c_IDX_W'(DEPTH);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE    = c_IDX_W'(1);
    localparam logic [ADDR_W:0]    c_DEPTH      = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]    c_CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [BANK_W:0]    c_NUM_BANKS  = (BANK_W + 1)'(NUM_BANKS);

    function automatic logic bank_ok(input logic [BANK_W-1:0] bank);
        return {1'b0, bank} < c_NUM_BANKS;
    endfunction

    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < c_DEPTH;
    endfunction

    function automatic logic [c_IDX_W-1:0] flat_idx(input logic [BANK_W-1:0]  bank,
                                                    input logic [c_IDX_W-1:0] addr);
        return c_IDX_W'(bank) * c_DEPTH_IDX + addr;
    endfunction

    bank_state_t          r_state;
    bank_state_t          w_state_next;
    logic [c_IDX_W-1:0]   r_clr_ptr;
    logic [c_IDX_W-1:0]   w_clr_ptr_next;
    logic [BANK_W-1:0]    r_zero_bank;
    logic                 r_wr_err;
    logic                 w_wr_acc;
    logic                 w_wr_ok;
    logic                 w_zero_go;
    logic [NUM_BANKS-1:0] w_loaded;
    logic                 w_mem_we;
    logic [c_IDX_W-1:0]   w_mem_widx;
    logic [KEY_W-1:0]     w_mem_wdata;
    logic                 w_rda_ok;
    logic                 w_rdb_ok;
    logic [KEY_W-1:0]     w_qa;
    logic [KEY_W-1:0]     w_qb;
    logic                 r_rda_valid;
    logic                 r_rda_zero;
    logic                 r_rdb_valid;
    logic                 r_rdb_zero;

    assign w_wr_acc  = i_wr_valid && (r_state == IDLE);
    assign w_wr_ok   = w_wr_acc && bank_ok(i_wr_bank) && addr_ok(i_wr_addr);
    assign w_zero_go = i_zero_req && (r_state == IDLE) && bank_ok(i_zero_bank);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= INIT;
            r_clr_ptr   <= '0;
            r_zero_bank <= '0;
            r_wr_err    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
            r_wr_err  <= w_wr_acc && !w_wr_ok;
            if (w_zero_go) begin
                r_zero_bank <= i_zero_bank;
            end
        end
    end

    // The single RAM write port is shared between the sweep and user writes.
    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        w_mem_we       = 1'b0;
        w_mem_widx     = '0;
        w_mem_wdata    = '0;
        case (r_state)
            INIT: begin
                w_mem_we       = 1'b1;
                w_mem_widx     = r_clr_ptr;
                w_clr_ptr_next = r_clr_ptr + c_IDX_ONE;
                if (r_clr_ptr == c_LAST_ENTRY) begin
                    w_state_next   = IDLE;
                    w_clr_ptr_next = '0;
                end
            end
            IDLE: begin
                w_mem_we    = w_wr_ok;
                w_mem_widx  = flat_idx(i_wr_bank, c_IDX_W'(i_wr_addr));
                w_mem_wdata = i_wr_key;
                if (w_zero_go) begin
                    w_state_next = CLEAR;
                end
            end
            CLEAR: begin
                w_mem_we       = 1'b1;
                w_mem_widx     = flat_idx(r_zero_bank, r_clr_ptr);
                w_clr_ptr_next = r_clr_ptr + c_IDX_ONE;
                if (r_clr_ptr == c_LAST_ADDR) begin
                    w_state_next   = IDLE;
                    w_clr_ptr_next = '0;
                end
            end
            default: begin
                w_state_next   = INIT;
                w_clr_ptr_next = '0;
            end
        endcase
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [ADDR_W:0] r_fill_cnt;
        logic            r_loaded;
        logic            w_wr_hit;
        logic            w_zero_hit;

        assign w_wr_hit   = w_wr_ok && (i_wr_bank == BANK_W'(b));
        assign w_zero_hit = w_zero_go && (i_zero_bank == BANK_W'(b));

        // A zeroize of this bank wins over a same-cycle write's fill update.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_fill_cnt <= '0;
                r_loaded   <= 1'b0;
            end else if (w_zero_hit) begin
                r_fill_cnt <= '0;
                r_loaded   <= 1'b0;
            end else if (w_wr_hit) begin
                if ({1'b0, i_wr_addr} == r_fill_cnt) begin
                    r_fill_cnt <= r_fill_cnt + c_CNT_ONE;
                    r_loaded   <= (r_fill_cnt == c_DEPTH - c_CNT_ONE);
                end else begin
                    r_fill_cnt <= (i_wr_addr == '0) ? c_CNT_ONE : '0;
                    r_loaded   <= 1'b0;
                end
            end
        end

        assign w_loaded[b] = r_loaded;
    end

    assign w_rda_ok = i_rda_en && bank_ok(i_rda_bank) && addr_ok(i_rda_addr) && w_loaded[i_rda_bank];
    assign w_rdb_ok = i_rdb_en && bank_ok(i_rdb_bank) && addr_ok(i_rdb_addr) && w_loaded[i_rdb_bank];

    key_ram_2r1w #(
        .WIDTH   (KEY_W),
        .ENTRIES (c_ENTRIES),
        .AW      (c_IDX_W)
    ) u_ram (
        .i_clk    (i_clk),
        .i_we     (w_mem_we),
        .i_waddr  (w_mem_widx),
        .i_wdata  (w_mem_wdata),
        .i_rea    (w_rda_ok),
        .i_raddra (flat_idx(i_rda_bank, c_IDX_W'(i_rda_addr))),
        .o_qa     (w_qa),
        .i_reb    (w_rdb_ok),
        .i_raddrb (flat_idx(i_rdb_bank, c_IDX_W'(i_rdb_addr))),
        .o_qb     (w_qb)
    );

    // The zero flag only moves on a read, so the key output holds between reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rda_valid <= 1'b0;
            r_rda_zero  <= 1'b1;
            r_rdb_valid <= 1'b0;
            r_rdb_zero  <= 1'b1;
        end else begin
            r_rda_valid <= i_rda_en;
            r_rdb_valid <= i_rdb_en;
            if (i_rda_en) begin
                r_rda_zero <= !w_rda_ok;
            end
            if (i_rdb_en) begin
                r_rdb_zero <= !w_rdb_ok;
            end
        end
    end

    assign o_rda_key     = r_rda_zero ? '0 : w_qa;
    assign o_rda_valid   = r_rda_valid;
    assign o_rda_err     = r_rda_valid && r_rda_zero;
    assign o_rdb_key     = r_rdb_zero ? '0 : w_qb;
    assign o_rdb_valid   = r_rdb_valid;
    assign o_rdb_err     = r_rdb_valid && r_rdb_zero;
    assign o_wr_err      = r_wr_err;
    assign o_wr_ready    = (r_state == IDLE);
    assign o_busy        = (r_state != IDLE);
    assign o_bank_loaded = w_loaded;

endmodule
`default_nettype wire

// File: tb/tb_round_key_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_key_bank
// Description : Self-checking bench for round_key_bank against a key-store
//               model plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_key_bank;
    import serpent_key_pkg::*;

    localparam int KW = 128;
    localparam int DP = 33;
    localparam int NB = 2;
    localparam int AW = 6;
    localparam int BW = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid, wr_ready, wr_err;
    logic [BW-1:0] wr_bank;
    logic [AW-1:0] wr_addr;
    logic [KW-1:0] wr_key;
    logic          rda_en, rda_valid, rda_err;
    logic [BW-1:0] rda_bank;
    logic [AW-1:0] rda_addr;
    logic [KW-1:0] rda_key;
    logic          rdb_en, rdb_valid, rdb_err;
    logic [BW-1:0] rdb_bank;
    logic [AW-1:0] rdb_addr;
    logic [KW-1:0] rdb_key;
    logic          zero_req, busy;
    logic [BW-1:0] zero_bank;
    logic [NB-1:0] loaded;

    always #5 clk = ~clk;

    round_key_bank dut (
        .i_clk(clk), .i_rst(rst),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_bank(wr_bank),
        .i_wr_addr(wr_addr), .i_wr_key(wr_key), .o_wr_err(wr_err),
        .i_rda_en(rda_en), .i_rda_bank(rda_bank), .i_rda_addr(rda_addr),
        .o_rda_key(rda_key), .o_rda_valid(rda_valid), .o_rda_err(rda_err),
        .i_rdb_en(rdb_en), .i_rdb_bank(rdb_bank), .i_rdb_addr(rdb_addr),
        .o_rdb_key(rdb_key), .o_rdb_valid(rdb_valid), .o_rdb_err(rdb_err),
        .i_zero_req(zero_req), .i_zero_bank(zero_bank),
        .o_busy(busy), .o_bank_loaded(loaded)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: bank contents, fill state, remaining busy cycles.
    logic [KW-1:0] m_mem [NB][DP];
    logic [NB-1:0] m_loaded;
    int            m_cnt [NB];
    int            m_busy;
    bit            m_started = 1'b0;
    logic          m_wr_err, m_va, m_ea, m_vb, m_eb;
    logic [KW-1:0] m_ka, m_kb;

    task automatic mrd(input logic en, input logic [BW-1:0] bk, input logic [AW-1:0] ad,
                       input logic [KW-1:0] kold, output logic v, output logic e,
                       output logic [KW-1:0] k);
        v = en;
        e = 1'b0;
        k = kold;
        if (en) begin
            if (int'(bk) < NB && int'(ad) < DP && m_loaded[bk]) begin
                k = m_mem[bk][ad];
            end else begin
                k = '0;
                e = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin : p_model
        bit idle;
        if (rst) begin
            m_started = 1'b1;
            m_busy    = NB * DP;
            m_loaded  = '0;
            for (int b = 0; b < NB; b++) begin
                m_cnt[b] = 0;
                for (int a = 0; a < DP; a++) m_mem[b][a] = '0;
            end
            m_wr_err = 1'b0;
            m_va = 1'b0; m_ea = 1'b0; m_ka = '0;
            m_vb = 1'b0; m_eb = 1'b0; m_kb = '0;
        end else begin
            idle = (m_busy == 0);
            mrd(rda_en, rda_bank, rda_addr, m_ka, m_va, m_ea, m_ka);
            mrd(rdb_en, rdb_bank, rdb_addr, m_kb, m_vb, m_eb, m_kb);
            m_wr_err = idle && wr_valid && (int'(wr_addr) >= DP);
            if (idle && wr_valid && int'(wr_addr) < DP) begin
                m_mem[wr_bank][wr_addr] = wr_key;
                if (int'(wr_addr) == m_cnt[wr_bank]) begin
                    m_cnt[wr_bank]++;
                    if (m_cnt[wr_bank] == DP) m_loaded[wr_bank] = 1'b1;
                end else begin
                    m_loaded[wr_bank] = 1'b0;
                    m_cnt[wr_bank]    = (wr_addr == 0) ? 1 : 0;
                end
            end
            if (!idle) begin
                m_busy--;
            end else if (zero_req) begin
                m_busy              = DP;
                m_loaded[zero_bank] = 1'b0;
                m_cnt[zero_bank]    = 0;
                for (int a = 0; a < DP; a++) m_mem[zero_bank][a] = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("busy", busy, m_busy != 0);
            chk("wr_ready", wr_ready, m_busy == 0);
            chk("wr_err", wr_err, m_wr_err);
            chk("bank_loaded", loaded, m_loaded);
            chk("rda_valid", rda_valid, m_va);
            chk("rda_err", rda_err, m_ea);
            chk("rda_key", rda_key, m_ka);
            chk("rdb_valid", rdb_valid, m_vb);
            chk("rdb_err", rdb_err, m_eb);
            chk("rdb_key", rdb_key, m_kb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank(input int bk, input bit inv);
        for (int a = 0; a < DP; a++) begin
            wr_valid = 1'b1;
            wr_bank  = BW'(bk);
            wr_addr  = AW'(a);
            wr_key   = inv ? ~KW'(a) : KW'(a) * KW'('h1111);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_bank = '0; wr_addr = '0; wr_key = '0;
        rda_en = 1'b0; rda_bank = '0; rda_addr = '0;
        rdb_en = 1'b0; rdb_bank = '0; rdb_addr = '0;
        zero_req = 1'b0; zero_bank = '0;
        repeat (3) tick();
        chk("reset_busy", busy, 1'b1);
        chk("reset_ready", wr_ready, 1'b0);
        rst = 1'b0;
        repeat (65) tick();
        chk("init_busy_65", busy, 1'b1);
        tick();
        chk("init_ready_66", wr_ready, 1'b1);
        chk("init_busy_66", busy, 1'b0);

        rda_en = 1'b1; rda_bank = BW'(BANK_DATA); rda_addr = 6'd0;
        tick(); rda_en = 1'b0;
        chk("unloaded_err", rda_err, 1'b1);
        chk("unloaded_key", rda_key, '0);

        load_bank(BANK_DATA, 1'b0);
        chk("load0", loaded, 2'b01);
        rda_en = 1'b1; rda_bank = 1'b0; rda_addr = 6'd5;
        tick(); rda_en = 1'b0;
        chk("rd0_5_key", rda_key, 128'h5555);
        chk("rd0_5_err", rda_err, 1'b0);

        load_bank(BANK_TWEAK, 1'b1);
        chk("load1", loaded, 2'b11);
        rda_en = 1'b1; rda_bank = 1'b0; rda_addr = 6'd7;
        rdb_en = 1'b1; rdb_bank = 1'b1; rdb_addr = 6'd7;
        tick(); rda_en = 1'b0; rdb_en = 1'b0;
        chk("dual_a_key", rda_key, 128'h7777);
        chk("dual_b_key", rdb_key, ~128'd7);
        chk("dual_valid", {rda_valid, rdb_valid}, 2'b11);

        wr_valid = 1'b1; wr_bank = 1'b1; wr_addr = 6'd3; wr_key = 128'hDEAD;
        tick(); wr_valid = 1'b0;
        chk("ooo_unload1", loaded, 2'b01);
        load_bank(BANK_TWEAK, 1'b1);
        chk("reload1", loaded, 2'b11);

        wr_valid = 1'b1; wr_bank = 1'b0; wr_addr = 6'd5; wr_key = 128'hABCD;
        rda_en = 1'b1; rda_bank = 1'b0; rda_addr = 6'd5;
        tick(); wr_valid = 1'b0; rda_en = 1'b0;
        chk("read_first", rda_key, 128'h5555);
        chk("rewrite_unload0", loaded, 2'b10);
        load_bank(BANK_DATA, 1'b0);

        zero_req = 1'b1; zero_bank = 1'b0;
        tick(); zero_req = 1'b0;
        chk("zero_busy", busy, 1'b1);
        chk("zero_loaded", loaded, 2'b10);
        rda_en = 1'b1; rda_bank = 1'b0; rda_addr = 6'd1;
        rdb_en = 1'b1; rdb_bank = 1'b1; rdb_addr = 6'd1;
        zero_req = 1'b1; zero_bank = 1'b1;
        wr_valid = 1'b1; wr_bank = 1'b1; wr_addr = 6'd0; wr_key = 128'h1;
        tick();
        rda_en = 1'b0; rdb_en = 1'b0; zero_req = 1'b0; wr_valid = 1'b0;
        chk("zero_rd_a_err", rda_err, 1'b1);
        chk("zero_rd_a_key", rda_key, '0);
        chk("zero_rd_b_key", rdb_key, ~128'd1);
        repeat (31) tick();
        chk("zero_busy_32", busy, 1'b1);
        tick();
        chk("zero_done_33", wr_ready, 1'b1);
        chk("zero_keep1", loaded, 2'b10);

        zero_req = 1'b1; zero_bank = 1'b1;
        tick(); zero_req = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        chk("rst_clear_loaded", loaded, 2'b00);
        chk("rst_clear_busy", busy, 1'b1);
        rst = 1'b0;
        repeat (65) tick();
        chk("reinit_busy_65", busy, 1'b1);
        tick();
        chk("reinit_ready_66", wr_ready, 1'b1);

        wr_valid = 1'b1; wr_bank = 1'b0; wr_addr = 6'd40; wr_key = 128'hBAD;
        tick(); wr_valid = 1'b0;
        chk("wr_err_pulse", wr_err, 1'b1);
        tick();
        chk("wr_err_clear", wr_err, 1'b0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
